// File: rtl/tile_feeder_pkg.sv
// Shared types and helpers for the skewed tile feeder.
package tile_feeder_pkg;

  // Controller states: fetch command, prime step 0, stream steps, report.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Step / reduction index width; wide enough for KMAX + max(M,N) - 1.
  localparam int T_W = 17;

  // Reduction index width for the default tile depth.
  localparam int KMAX_DEFAULT = 1024;
  localparam int K_W = $clog2(KMAX_DEFAULT);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/skew_lane_gather.sv
// Maps a step index t to one diagonally-skewed lane vector: lane gi reads
// element k = t - gi of its tile row/column, or drives zero when k is
// outside [0, kq). Purely combinational; the caller registers the result.
module skew_lane_gather
  import tile_feeder_pkg::*;
#(
  parameter int LANES   = 8,
  parameter int KMAX    = 1024,
  parameter int DATA_W  = 32,
  parameter int STRIDE  = 1024,
  parameter bit K_MAJOR = 1'b0   // 0: (lane,k) at lane*STRIDE+k, 1: at k*STRIDE+lane
) (
  input  logic [T_W-1:0]               t,
  input  logic [T_W-1:0]               kq,
  input  logic [LANES*KMAX*DATA_W-1:0] tile,
  output logic [LANES*DATA_W-1:0]      vec,
  output logic [LANES-1:0]             vld
);

  localparam int ELEMS = LANES * KMAX;
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  // Flat tile viewed as an element array so the per-lane mux indexes cleanly.
  logic [DATA_W-1:0] elem [ELEMS];

  genvar gi;
  generate
    for (gi = 0; gi < ELEMS; gi++) begin : g_elem
      assign elem[gi] = tile[gi*DATA_W +: DATA_W];
    end

    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic signed [T_W:0] LANE_S = (T_W+1)'(gi);

      logic signed [T_W:0] k_s;
      logic [T_W-1:0]      k_u;
      logic [IDX_W-1:0]    idx;
      logic                in_range;

      // Signed skew so lanes ahead of the wavefront see a negative k.
      assign k_s      = $signed({1'b0, t}) - LANE_S;
      assign in_range = (k_s >= 0) && (k_s < $signed({1'b0, kq}));
      assign k_u      = k_s[T_W-1:0];

      if (K_MAJOR) begin : g_km
        assign idx = IDX_W'(int'(k_u) * STRIDE + gi);
      end else begin : g_rm
        assign idx = IDX_W'(gi * STRIDE + int'(k_u));
      end

      assign vec[gi*DATA_W +: DATA_W] = in_range ? elem[idx] : '0;
      assign vld[gi]                  = in_range;
    end
  endgenerate

endmodule

// File: rtl/tile_skew_feeder.sv
// Streams a loaded W (M x KMAX) and X (KMAX x N) tile pair into an
// output-stationary systolic array as diagonally skewed A/B step vectors,
// one step per valid/ready handshake.
module tile_skew_feeder
  import tile_feeder_pkg::*;
#(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int KMAX   = 1024,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                K_len,
  input  logic [M*KMAX*DATA_W-1:0]   W_tile_flat,
  input  logic [KMAX*N*DATA_W-1:0]   X_tile_flat,
  output logic                       busy,
  output logic                       done,
  output logic                       err_len,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [M*DATA_W-1:0]        a_vec,
  output logic [M-1:0]               a_vld,
  output logic [N*DATA_W-1:0]        b_vec,
  output logic [N-1:0]               b_vld
);

  localparam int MAXMN = max2(M, N);

  state_t                state_reg, state_next;
  logic [T_W-1:0]        kq_reg, kq_next;
  logic [T_W-1:0]        t_reg, t_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  err_len_reg, err_len_next;
  logic                  err_arm_reg, err_arm_next;
  logic                  out_valid_reg, out_valid_next;
  logic                  out_last_reg, out_last_next;
  logic [M*DATA_W-1:0]   a_vec_reg, a_vec_next;
  logic [M-1:0]          a_vld_reg, a_vld_next;
  logic [N*DATA_W-1:0]   b_vec_reg, b_vec_next;
  logic [N-1:0]          b_vld_reg, b_vld_next;

  logic [T_W-1:0]        t_sel;
  logic [T_W-1:0]        t_last;
  logic                  fire;
  logic                  len_bad;
  logic [M*DATA_W-1:0]   ga_vec;
  logic [M-1:0]          ga_vld;
  logic [N*DATA_W-1:0]   gb_vec;
  logic [N-1:0]          gb_vld;

  // Step about to be loaded: 0 when priming, otherwise the successor of t.
  assign t_sel   = (state_reg == LOAD) ? '0 : t_reg + T_W'(1);
  // Index of the final step, T-1 = kq + max(M,N) - 2 (kq >= 1 here).
  assign t_last  = kq_reg + T_W'(MAXMN) - T_W'(2);
  assign fire    = out_valid_reg & out_ready;
  assign len_bad = (K_len == 16'd0) || ({1'b0, K_len} > T_W'(KMAX));

  skew_lane_gather #(
    .LANES   (M),
    .KMAX    (KMAX),
    .DATA_W  (DATA_W),
    .STRIDE  (KMAX),
    .K_MAJOR (1'b0)
  ) u_gather_a (
    .t    (t_sel),
    .kq   (kq_reg),
    .tile (W_tile_flat),
    .vec  (ga_vec),
    .vld  (ga_vld)
  );

  skew_lane_gather #(
    .LANES   (N),
    .KMAX    (KMAX),
    .DATA_W  (DATA_W),
    .STRIDE  (N),
    .K_MAJOR (1'b1)
  ) u_gather_b (
    .t    (t_sel),
    .kq   (kq_reg),
    .tile (X_tile_flat),
    .vec  (gb_vec),
    .vld  (gb_vld)
  );

  // Next-state and output-register logic; outputs hold unless a step fires.
  always_comb begin
    state_next     = state_reg;
    kq_next        = kq_reg;
    t_next         = t_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    err_len_next   = 1'b0;
    err_arm_next   = err_arm_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    a_vec_next     = a_vec_reg;
    a_vld_next     = a_vld_reg;
    b_vec_next     = b_vec_reg;
    b_vld_next     = b_vld_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          kq_next = {1'b0, K_len};
          t_next  = '0;
          if (len_bad) begin
            err_arm_next = 1'b1;
            state_next   = FIN;
          end else begin
            busy_next  = 1'b1;
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        t_next         = t_sel;
        a_vec_next     = ga_vec;
        a_vld_next     = ga_vld;
        b_vec_next     = gb_vec;
        b_vld_next     = gb_vld;
        out_valid_next = 1'b1;
        out_last_next  = (t_sel == t_last);
        state_next     = RUN;
      end
      RUN: begin
        if (fire) begin
          if (t_reg == t_last) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            a_vec_next     = '0;
            a_vld_next     = '0;
            b_vec_next     = '0;
            b_vld_next     = '0;
            state_next     = FIN;
          end else begin
            t_next        = t_sel;
            a_vec_next    = ga_vec;
            a_vld_next    = ga_vld;
            b_vec_next    = gb_vec;
            b_vld_next    = gb_vld;
            out_last_next = (t_sel == t_last);
          end
        end
      end
      FIN: begin
        done_next    = 1'b1;
        err_len_next = err_arm_reg;
        err_arm_next = 1'b0;
        busy_next    = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset aborts any command without done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      kq_reg        <= '0;
      t_reg         <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_len_reg   <= 1'b0;
      err_arm_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      a_vec_reg     <= '0;
      a_vld_reg     <= '0;
      b_vec_reg     <= '0;
      b_vld_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      kq_reg        <= kq_next;
      t_reg         <= t_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_len_reg   <= err_len_next;
      err_arm_reg   <= err_arm_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      a_vec_reg     <= a_vec_next;
      a_vld_reg     <= a_vld_next;
      b_vec_reg     <= b_vec_next;
      b_vld_reg     <= b_vld_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err_len   = err_len_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign a_vec     = a_vec_reg;
  assign a_vld     = a_vld_reg;
  assign b_vec     = b_vec_reg;
  assign b_vld     = b_vld_reg;

endmodule
